// File: rtl/async_packet_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : async_packet_serializer_if
// Brief    : Message-in / packet-out bundle for the packet serializer.
//            Carries the start request, the datagram, the packet strobe and
//            the status signals.
// Revision : 1.0 - initial release
// ============================================================================
interface async_packet_serializer_if #(
  parameter int MSG_W = 64,
  parameter int PKT_W = 6
);
  localparam int NUM_PKTS = (MSG_W + PKT_W - 1) / PKT_W;
  localparam int IDX_W    = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;

  logic             start;
  logic [MSG_W-1:0] datagram_in;
  logic             busy;
  logic [PKT_W-1:0] packet_out;
  logic [IDX_W-1:0] packet_idx;
  logic             frame_first;
  logic             packet_pulse;
  logic             transmit_ctrl;

  // Message source / link consumer side
  modport master (
    output start, datagram_in,
    input  busy, packet_out, packet_idx, frame_first, packet_pulse, transmit_ctrl
  );

  // Serializer side
  modport slave (
    input  start, datagram_in,
    output busy, packet_out, packet_idx, frame_first, packet_pulse, transmit_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/async_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module   : async_packet_serializer
// Brief    : Captures a datagram on start and sends it as a sequence of
//            PKT_W-bit packets, each framed by a setup period followed by a
//            strobe pulse; pulses transmit_ctrl for one cycle when complete.
// Revision : 1.0 - initial release
// ============================================================================
module async_packet_serializer #(
  parameter int MSG_W        = 64,
  parameter int PKT_W        = 6,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic                         clk_send,
  input  logic                         rst_n,
  async_packet_serializer_if.slave     bus
);

  localparam int NUM_PKTS = (MSG_W + PKT_W - 1) / PKT_W;
  localparam int IDX_W    = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
  localparam int BUF_W    = NUM_PKTS * PKT_W;
  localparam int MAX_CYC  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  // Counter holds (cycles - 1), so clog2 of the longest phase is enough.
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PKTS - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic [NUM_PKTS-1:0][PKT_W-1:0]    buf_q, buf_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;

  logic [BUF_W-1:0]                  ext_w;
  logic [IDX_W-1:0]                  chunk_sel_w;

  // Zero-extend the datagram to a whole number of packets
  always_comb begin
    ext_w              = '0;
    ext_w[MSG_W-1:0]   = bus.datagram_in;
  end

  // Map packet index to buffer chunk according to the configured order
  always_comb begin
    chunk_sel_w = idx_q;
    if (MSB_FIRST != 0) begin
      chunk_sel_w = LAST_IDX - idx_q;
    end
  end

  // State register, buffer, packet index and phase counter
  always_ff @(posedge clk_send) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: setup/pulse phase sequencing per packet
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (bus.start) begin
          buf_d   = ext_w;
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = SETUP_LOAD;
          state_d = SETUP;
        end
      end
      DONE: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; all zero while idle
  always_comb begin
    bus.busy          = (state_q != IDLE);
    bus.packet_pulse  = (state_q == PULSE);
    bus.transmit_ctrl = (state_q == DONE);
    bus.packet_idx    = idx_q;
    bus.packet_out    = (state_q != IDLE) ? buf_q[chunk_sel_w] : '0;
    bus.frame_first   = (state_q != IDLE) && (state_q != DONE) && (idx_q == '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_async_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_packet_serializer
// Brief    : Self-checking bench for async_packet_serializer: three
//            configurations (LSB-first, MSB-first, multi-cycle phases) driven
//            from a cycle table plus directed corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_packet_serializer;

  logic clk_send = 1'b0;
  logic rst_n;
  always #5 clk_send = ~clk_send;

  async_packet_serializer_if #(.MSG_W(16), .PKT_W(6)) if_a ();
  async_packet_serializer_if #(.MSG_W(16), .PKT_W(6)) if_b ();
  async_packet_serializer_if #(.MSG_W(12), .PKT_W(6)) if_c ();

  async_packet_serializer #(.MSG_W(16), .PKT_W(6), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .MSB_FIRST(0))
    u_a (.clk_send(clk_send), .rst_n(rst_n), .bus(if_a));
  async_packet_serializer #(.MSG_W(16), .PKT_W(6), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .MSB_FIRST(1))
    u_b (.clk_send(clk_send), .rst_n(rst_n), .bus(if_b));
  async_packet_serializer #(.MSG_W(12), .PKT_W(6), .SETUP_CYCLES(2), .PULSE_CYCLES(3), .MSB_FIRST(0))
    u_c (.clk_send(clk_send), .rst_n(rst_n), .bus(if_c));

  int errors = 0;
  int checks = 0;

  // Observed outputs of the currently selected DUT
  int         sel;
  logic       s_busy, s_ff, s_pulse, s_tc;
  logic [5:0] s_pkt;
  logic [1:0] s_idx;

  always_comb begin
    s_busy = if_a.busy; s_pkt = if_a.packet_out; s_idx = if_a.packet_idx;
    s_ff = if_a.frame_first; s_pulse = if_a.packet_pulse; s_tc = if_a.transmit_ctrl;
    if (sel == 1) begin
      s_busy = if_b.busy; s_pkt = if_b.packet_out; s_idx = if_b.packet_idx;
      s_ff = if_b.frame_first; s_pulse = if_b.packet_pulse; s_tc = if_b.transmit_ctrl;
    end else if (sel == 2) begin
      s_busy = if_c.busy; s_pkt = if_c.packet_out; s_idx = {1'b0, if_c.packet_idx};
      s_ff = if_c.frame_first; s_pulse = if_c.packet_pulse; s_tc = if_c.transmit_ctrl;
    end
  end

  typedef struct {
    int         dut;
    logic       start;
    logic [15:0] din;
    logic       busy;
    logic [5:0] pkt;
    logic [1:0] idx;
    logic       ff;
    logic       pulse;
    logic       tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int dut, logic st, logic [15:0] din, logic busy,
                              logic [5:0] pkt, logic [1:0] idx, logic ff, logic pulse, logic tc);
    vec_t v;
    v.dut = dut; v.start = st; v.din = din; v.busy = busy; v.pkt = pkt;
    v.idx = idx; v.ff = ff; v.pulse = pulse; v.tc = tc;
    return v;
  endfunction

  // Reference chunk k (LSB-first) of a 16-bit datagram, zero-extended
  function automatic logic [5:0] chunk(logic [15:0] d, int k);
    logic [17:0] e;
    e = {2'b00, d};
    return e[k*6 +: 6];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic busy, input logic [5:0] pkt,
                            input logic [1:0] idx, input logic ff, input logic pulse, input logic tc);
    check({tag, ".busy"},  32'(s_busy),  32'(busy));
    check({tag, ".pkt"},   32'(s_pkt),   32'(pkt));
    check({tag, ".idx"},   32'(s_idx),   32'(idx));
    check({tag, ".ff"},    32'(s_ff),    32'(ff));
    check({tag, ".pulse"}, 32'(s_pulse), 32'(pulse));
    check({tag, ".tc"},    32'(s_tc),    32'(tc));
  endtask

  task automatic drive(input int d, input logic st, input logic [15:0] din);
    sel = d;
    if_a.start = (d == 0) && st; if_a.datagram_in = din;
    if_b.start = (d == 1) && st; if_b.datagram_in = din;
    if_c.start = (d == 2) && st; if_c.datagram_in = din[11:0];
  endtask

  task automatic step();
    @(posedge clk_send);
    #1;
  endtask

  logic [15:0] dv [0:11];
  logic        ob_busy [0:10];
  logic        ob_tc   [0:10];
  logic        ob_ff   [0:10];
  logic [5:0]  ob_pkt  [0:10];

  initial begin
    // ---------------- vector table: each row = one cycle ----------------
    // Config A, LSB-first, 16'hABCD -> 0D, 2F, 0A
    vecs.push_back(mk(0, 1, 16'hABCD, 1, 6'h0D, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 6'h0D, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 6'h2F, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 6'h2F, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 6'h0A, 2, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 6'h0A, 2, 0, 1, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 6'h0A, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 6'h00, 0, 0, 0, 0));
    // Config B, MSB-first, 16'hABCD -> 0A, 2F, 0D
    vecs.push_back(mk(1, 1, 16'hABCD, 1, 6'h0A, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 6'h0A, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 6'h2F, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 6'h2F, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 6'h0D, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 6'h0D, 2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 6'h0D, 2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 6'h00, 0, 0, 0, 0));
    // Config C, 12-bit, setup 2 / pulse 3, 12'hFC3 -> 03, 3F
    vecs.push_back(mk(2, 1, 16'h0FC3, 1, 6'h03, 0, 1, 0, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h03, 0, 1, 0, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h03, 0, 1, 1, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h03, 0, 1, 1, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h03, 0, 1, 1, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h3F, 1, 0, 0, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h3F, 1, 0, 0, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h3F, 1, 0, 1, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h3F, 1, 0, 1, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h3F, 1, 0, 1, 0));
    vecs.push_back(mk(2, 0, 16'h0000, 1, 6'h3F, 1, 0, 0, 1));
    vecs.push_back(mk(2, 0, 16'h0000, 0, 6'h00, 0, 0, 0, 0));

    // ---------------- reset held 3 cycles, start asserted ----------------
    rst_n = 1'b0;
    drive(0, 1, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("reset_a", 0, 6'h00, 0, 0, 0, 0);
    end
    sel = 2; #1;
    check_outs("reset_c", 0, 6'h00, 0, 0, 0, 0);

    // ---------------- idle with start low ----------------
    rst_n = 1'b1;
    drive(0, 0, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      step();
      check_outs("idle", 0, 6'h00, 0, 0, 0, 0);
    end

    // ---------------- table-driven cycles ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dut, vecs[i].start, vecs[i].din);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].pkt, vecs[i].idx,
                 vecs[i].ff, vecs[i].pulse, vecs[i].tc);
    end

    // ---------------- start held high, datagram changing ----------------
    for (int i = 0; i < 12; i++) dv[i] = 16'h1234 + 16'(i) * 16'h0F1D;
    for (int i = 0; i < 11; i++) begin
      drive(0, 1, dv[i]);
      step();
      ob_busy[i] = s_busy; ob_tc[i] = s_tc; ob_ff[i] = s_ff; ob_pkt[i] = s_pkt;
    end
    drive(0, 0, 16'h0000);
    check("hold.pkt0",  32'(ob_pkt[0]), 32'(chunk(dv[0], 0)));
    check("hold.pkt1",  32'(ob_pkt[2]), 32'(chunk(dv[0], 1)));
    check("hold.pkt2",  32'(ob_pkt[4]), 32'(chunk(dv[0], 2)));
    check("hold.tc7",   32'(ob_tc[6]),  32'(1));
    check("hold.busy8", 32'(ob_busy[7]), 32'(0));
    check("hold.busy9", 32'(ob_busy[8]), 32'(1));
    check("hold.ff9",   32'(ob_ff[8]),  32'(1));
    check("hold.repkt0", 32'(ob_pkt[8]),  32'(chunk(dv[8], 0)));
    check("hold.repkt1", 32'(ob_pkt[10]), 32'(chunk(dv[8], 1)));
    for (int i = 0; i < 8; i++) step();
    check("hold.drained", 32'(s_busy), 32'(0));

    // ---------------- reset during second packet's pulse ----------------
    drive(0, 1, 16'hABCD);
    step();
    drive(0, 0, 16'h0000);
    step(); step(); step();
    check("abort.pulse", 32'(s_pulse), 32'(1));
    check("abort.idx",   32'(s_idx),   32'(1));
    rst_n = 1'b0;
    step();
    check_outs("abort.rst", 0, 6'h00, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort.no_tc", 32'(s_tc), 32'(0));
    end
    drive(0, 1, 16'h5A5A);
    step();
    drive(0, 0, 16'h0000);
    check_outs("fresh", 1, chunk(16'h5A5A, 0), 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step();
    check("fresh.drained", 32'(s_busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
